// File: rtl/pong_video_pkg.sv
// pong_video_pkg: shared video geometry and net placement helpers for the game renderers.
package pong_video_pkg;
   localparam int H_VIDEO = 640;
   localparam int V_VIDEO = 480;
   localparam int COORD_W = 10;
   function automatic int line_centre(input int i, input int n, input int h);
      return ((i + 1) * h) / (n + 1);
   endfunction
endpackage

// File: rtl/mod_phase_counter.sv
// mod_phase_counter: 6-bit register kept modulo PERIOD with load, increment-wrap and +/-step-wrap.
module mod_phase_counter #(
   parameter int PERIOD = 24,
   parameter logic [5:0] INIT = 6'd18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] load_val,
   input  logic       inc,
   input  logic       step_en,
   input  logic       step_dir,
   input  logic [3:0] step,
   output logic [5:0] value
);
   logic [6:0] up;
   logic [5:0] up_wrap, down, nxt;
   always_comb begin
      up = {1'b0, value} + {3'b0, step};
      up_wrap = up >= 7'(PERIOD) ? 6'(up - 7'(PERIOD)) : up[5:0];
      // step < PERIOD, so adding PERIOD once is enough to undo an underflow
      down = value >= {2'b0, step} ? value - {2'b0, step} : value + 6'(PERIOD) - {2'b0, step};
      nxt = load ? load_val
          : inc ? (value == 6'(PERIOD - 1) ? 6'd0 : value + 6'd1)
          : step_en ? (step_dir ? down : up_wrap)
          : value;
   end
   always_ff @(posedge clk)
      value <= rst ? INIT : nxt;
endmodule

// File: rtl/dashed_net_renderer.sv
// dashed_net_renderer: draws NUM_LINES evenly spaced dashed vertical nets with scrolling and solid override.
module dashed_net_renderer
   import pong_video_pkg::line_centre;
#(
   parameter int H_VIDEO     = 640,
   parameter int NUM_LINES   = 1,
   parameter int NET_WIDTH   = 12,
   parameter int DASH_HEIGHT = 12,
   parameter int GAP_HEIGHT  = 12,
   parameter int START_PHASE = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       video_on,
   input  logic       frame_start,
   input  logic       scroll_en,
   input  logic       scroll_dir,
   input  logic [3:0] scroll_step,
   input  logic       solid_mode,
   output logic       pixel_on,
   output logic [1:0] line_id
);
   localparam int PERIOD = DASH_HEIGHT + GAP_HEIGHT;
   logic [5:0] base_phase, row_phase;
   logic [NUM_LINES-1:0] hit;
   logic [1:0] id;
   logic row_edge, lit, on;
   assign row_edge = video_on && pixel_x == 10'd0;
   mod_phase_counter #(.PERIOD(PERIOD), .INIT(6'(START_PHASE))) u_base (
      .clk(clk), .rst(rst), .load(1'b0), .load_val(6'd0), .inc(1'b0),
      .step_en(frame_start && scroll_en), .step_dir(scroll_dir), .step(scroll_step),
      .value(base_phase)
   );
   // the row-0 load sees the register value, so a same-cycle scroll lands next frame
   mod_phase_counter #(.PERIOD(PERIOD), .INIT(6'(START_PHASE))) u_row (
      .clk(clk), .rst(rst), .load(row_edge && pixel_y == 10'd0), .load_val(base_phase),
      .inc(row_edge && pixel_y != 10'd0), .step_en(1'b0), .step_dir(1'b0), .step(4'd0),
      .value(row_phase)
   );
   for (genvar i = 0; i < NUM_LINES; i++) begin : g_col
      localparam int LO = line_centre(i, NUM_LINES, H_VIDEO) - NET_WIDTH / 2;
      localparam int HI = LO + NET_WIDTH - 1;
      assign hit[i] = int'(pixel_x) >= LO && int'(pixel_x) <= HI;
   end
   always_comb begin
      id = 2'd0;
      for (int k = NUM_LINES - 1; k >= 0; k--)
         if (hit[k]) id = 2'(k);
   end
   assign lit = solid_mode || row_phase < 6'(DASH_HEIGHT);
   assign on = video_on && lit && |hit;
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_on <= 1'b0;
         line_id <= 2'd0;
      end else begin
         pixel_on <= on;
         line_id <= on ? id : 2'd0;
      end
   end
endmodule
